// File: rtl/program_load_ctrl_pkg.sv
// Shared definitions for the program load controller: default widths,
// the session state encoding and the load-length range helper.
package program_load_ctrl_pkg;

  // Default geometry of the instruction memory and the run-cycle counter.
  localparam int ADDR_W_DEF  = 10;
  localparam int INSTR_W_DEF = 32;
  localparam int RUN_W_DEF   = 16;

  // Session states. The top keeps a plain 2-bit state register and names
  // the encodings through localparams taken from this enum.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } plc_state_e;

  // A load length is usable when it names at least one word and no more
  // words than the instruction memory holds.
  function automatic logic plc_len_ok(input int unsigned len,
                                      input int unsigned addr_w);
    return (len != 0) && (len <= (32'd1 << addr_w));
  endfunction

endpackage : program_load_ctrl_pkg

// File: rtl/program_load_ctrl_ld_counter.sv
// Up-counter with synchronous clear, count enable and a terminal-match flag.
// The count saturates at all-ones so it never wraps back to zero.
module ld_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] match_val,
  output logic [W-1:0] count,
  output logic         match
);

  logic at_max;

  assign at_max = (count == {W{1'b1}});

  // Count register: reset and clear dominate, then a saturating increment.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours; blocking here would create order races.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !at_max) begin
      count <= count + W'(1);
    end
  end

  // Terminal flag compares the live count against the caller's target.
  assign match = (count == match_val);

endmodule : ld_counter

// File: rtl/program_load_ctrl.sv
// Program load controller: streams a block of instruction words into the
// core's instruction memory while holding the core, then releases the core
// for a fixed number of cycles and reports the end of the session.
module program_load_ctrl
  import program_load_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int RUN_W   = RUN_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W:0]    load_len,
  input  logic [RUN_W-1:0]   run_cycles,
  input  logic               abort,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_waddr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               core_hold,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // State encodings, kept as plain constants for the legacy state register.
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] LOAD = ST_LOAD;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [ADDR_W:0]    load_len_q;
  logic [RUN_W-1:0]   run_cycles_q;
  logic               err_q;

  logic               st_idle;
  logic               st_load;
  logic               st_run;
  logic               st_done;

  logic               start_req;
  logic               len_ok;
  logic               start_acc;
  logic               start_rej;
  logic               hs;
  logic               hs_last;

  logic [ADDR_W:0]    word_cnt;
  logic [ADDR_W:0]    word_match_val;
  logic               word_last;
  logic [RUN_W-1:0]   run_cnt;
  logic [RUN_W-1:0]   run_match_val;
  logic               run_last;

  assign st_idle = (state_q == IDLE);
  assign st_load = (state_q == LOAD);
  assign st_run  = (state_q == RUN);
  assign st_done = (state_q == DONE);

  // A start only counts in IDLE, and abort in the same cycle overrides it.
  assign start_req = st_idle && start && !abort;
  assign len_ok    = plc_len_ok(32'(load_len), ADDR_W);
  assign start_acc = start_req && len_ok;
  assign start_rej = start_req && !len_ok;

  // The controller is ready for every LOAD cycle; abort does not block the
  // handshake, so a word offered in the abort cycle is still written.
  assign hs      = st_load && in_valid;
  assign hs_last = hs && word_last;

  // Targets are the last index of each phase (length minus one).
  assign word_match_val = load_len_q - {{ADDR_W{1'b0}}, 1'b1};
  assign run_match_val  = run_cycles_q - {{(RUN_W-1){1'b0}}, 1'b1};

  // Word counter: cleared when a session is accepted, steps per handshake.
  // One bit wider than the address so a full-memory load never wraps.
  ld_counter #(
    .W (ADDR_W + 1)
  ) u_word_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_acc),
    .en        (hs),
    .match_val (word_match_val),
    .count     (word_cnt),
    .match     (word_last)
  );

  // Run counter: cleared on the last load handshake, steps every RUN cycle.
  ld_counter #(
    .W (RUN_W)
  ) u_run_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (hs_last),
    .en        (st_run),
    .match_val (run_match_val),
    .count     (run_cnt),
    .match     (run_last)
  );

  // Next-state logic; abort returns to IDLE from anywhere.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (hs_last) begin
          state_d = (run_cycles_q == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (run_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort) begin
      state_d = IDLE;
    end
  end

  // State, session parameters and the registered reject pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      load_len_q   <= '0;
      run_cycles_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= start_rej;
      if (start_acc) begin
        load_len_q   <= load_len;
        run_cycles_q <= run_cycles;
      end
    end
  end

  // Outputs decode the state; while rst is high they show the idle values
  // even before the reset edge has cleared the state register.
  assign in_ready   = st_load && !rst;
  assign imem_we    = hs && !rst;
  assign imem_waddr = rst ? '0 : word_cnt[ADDR_W-1:0];
  assign imem_wdata = in_data;
  assign core_hold  = !(st_run && !rst);
  assign busy       = !st_idle && !rst;
  assign done       = st_done && !abort && !rst;
  assign err        = err_q && !rst;

endmodule : program_load_ctrl

// File: doc/program_load_ctrl.md
PROGRAM_LOAD_CTRL -- requirements
Module: program_load_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: instruction-memory address width.
REQ-002 SHALL have parameter INSTR_W, default 32: instruction word width.
REQ-003 SHALL have parameter RUN_W, default 16: run-cycle counter width.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1: single-cycle request to begin a load/run session.
REQ-007 SHALL have port load_len  input  ADDR_W+1: number of words to load, sampled on accepted start.
REQ-008 SHALL have port run_cycles  input  RUN_W: execute-phase length in cycles, sampled on accepted start.
REQ-009 SHALL have port abort  input  1: terminate any session.
REQ-010 SHALL have port in_valid  input  1: loader word valid.
REQ-011 SHALL have port in_data  input  INSTR_W: loader word.
REQ-012 SHALL have port in_ready  output  1: controller accepts a word.
REQ-013 SHALL have port imem_we  output  1: instruction-memory write strobe.
REQ-014 SHALL have port imem_waddr  output  ADDR_W: instruction-memory write address.
REQ-015 SHALL have port imem_wdata  output  INSTR_W: instruction-memory write data.
REQ-016 SHALL have port core_hold  output  1: high holds the core in load mode (drives core ins_write); low lets it execute.
REQ-017 SHALL have port busy  output  1: session in progress.
REQ-018 SHALL have port done  output  1: one-cycle pulse at normal session end.
REQ-019 SHALL have port err  output  1: one-cycle pulse on a rejected start.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-021 IDLE: start=1 with 1 <= load_len <= 2**ADDR_W -> LOAD; latch load_len and run_cycles; clear word counter.
REQ-022 IDLE: start=1 with load_len=0 or load_len > 2**ADDR_W -> stay IDLE; err=1 the following cycle.
REQ-023 SHALL ignore start outside IDLE.
REQ-024 LOAD: in_ready=1; handshake is in_valid & in_ready.
REQ-025 On handshake: imem_we=1 same cycle (combinational); imem_waddr = word counter; imem_wdata = in_data; zero latency.
REQ-026 Word counter SHALL increment per handshake, start at 0, and never wrap; at most 2**ADDR_W writes per session.
REQ-027 Handshake on the last word (counter = latched load_len-1) -> RUN next cycle, or DONE if latched run_cycles=0.
REQ-028 in_valid stalls in LOAD SHALL hold state and counter indefinitely.
REQ-029 core_hold=1 in IDLE, LOAD and DONE; core_hold=0 only in RUN.
REQ-030 RUN: cycle counter from 0; counter = latched run_cycles-1 -> DONE next cycle; exactly run_cycles cycles with core_hold=0.
REQ-031 DONE: done=1 for exactly one cycle, then IDLE.
REQ-032 busy=1 in LOAD, RUN and DONE; busy=0 in IDLE.
REQ-033 abort=1 in any state -> IDLE next cycle; no done or err pulse; in LOAD, an abort-cycle handshake SHALL still write that word.
REQ-034 abort and start in the same IDLE cycle: abort wins; start is ignored.
REQ-035 in_ready and imem_we SHALL be 0 outside LOAD.

Reset
REQ-036 rst=1 at a clock edge SHALL force IDLE and zero counters and latches, in any state including mid-LOAD and mid-RUN.
REQ-037 Outputs during and after reset until next start: in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=in_data, core_hold=1, busy=0, done=0, err=0.

Structure
REQ-038 Shared package SHALL hold the state enum (IDLE, LOAD, RUN, DONE) and the default widths ADDR_W=10, INSTR_W=32, RUN_W=16.
REQ-039 SHALL contain one sub-module, ld_counter: an up-counter with clear, enable and terminal-match, instantiated twice (word counter, run counter).

Verification
REQ-040 start, load_len=3, run_cycles=5, 3 back-to-back words A,B,C -> writes addr0=A, addr1=B, addr2=C; core_hold low exactly 5 cycles; done pulse once.
REQ-041 load_len=2 with in_valid toggling 1,0,0,1 -> exactly 2 writes at addr 0,1; no write on stall cycles.
REQ-042 start with load_len=0, then with load_len=1025 (ADDR_W=10) -> err pulse each time; busy stays 0; no writes.
REQ-043 load_len=1024, run_cycles=0 -> last write at addr 1023; DONE directly after LOAD; core_hold never low.
REQ-044 rst pulsed at RUN cycle 2, and abort at LOAD word 1 -> IDLE next cycle; core_hold=1; no done pulse.
REQ-045 start asserted during LOAD -> ignored; latched load_len and run_cycles unchanged.
